// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-port word-organised data memory with a valid/ready
//                request interface. Each request sees a programmable number
//                of wait cycles, returns the pre-write word, then applies
//                byte-lane writes.
//                Optional range checking: define DMEM_RESPONDER_ERR_EN to
//                add dmem_err_o and reject out-of-range addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_valid_i,
    output logic        dmem_ready_o,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_we_i,
    output logic [31:0] dmem_rdata_o
`ifdef DMEM_RESPONDER_ERR_EN
    ,
    output logic        dmem_err_o
`endif
);

    localparam int         c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_run;
    logic                r_ready;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_addr_err;
    logic                w_enter_resp;
    logic                w_wr_en;
    logic [31:0]         w_rd_word;
    logic                w_unused_addr;

    // Storage array; deliberately has no reset so contents survive rst_n.
    logic [31:0]         r_mem [DEPTH_WORDS];

    // Word index; the byte offset is ignored.
    assign w_idx = dmem_addr_i[c_IDX_W+1:2];

`ifdef DMEM_RESPONDER_ERR_EN
    // Any address bit above the array span marks the request out of range.
    assign w_addr_err    = |dmem_addr_i[31:c_IDX_W+2];
    assign w_unused_addr = ^dmem_addr_i[1:0];
`else
    // Upper address bits are don't-care: the index wraps modulo the depth.
    assign w_addr_err    = 1'b0;
    assign w_unused_addr = ^{dmem_addr_i[31:c_IDX_W+2], dmem_addr_i[1:0]};
`endif

    // r_run is low while in reset and for the first edge after release, so
    // no request can be accepted or write the array while reset is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; a dropped valid in WAIT aborts the request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (dmem_valid_i && r_run) begin
                    if (c_WAIT == 4'd0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!dmem_valid_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RESP;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                // A valid still high here is handled as a new request from IDLE.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // RESP is never re-entered from itself, so this marks the entry edge only.
    assign w_enter_resp = (w_state_nxt == ST_RESP);
    assign w_wr_en      = w_enter_resp && !w_addr_err && (dmem_we_i != 4'h0);
    assign w_rd_word    = w_addr_err ? 32'h0 : r_mem[w_idx];

    // Registered response: strobe, pre-write read data and range error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_enter_resp;
            r_err   <= w_enter_resp && w_addr_err;
            if (w_enter_resp) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // Byte-lane write on the RESP entry edge; the read above samples the old word.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_we_i[i]) begin
                    r_mem[w_idx][8*i +: 8] <= dmem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign dmem_ready_o = r_ready;
    assign dmem_rdata_o = r_rdata;
`ifdef DMEM_RESPONDER_ERR_EN
    assign dmem_err_o   = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Three instances with
//                WAIT_CYCLES 0, 1 and 3 share the request fields; each has
//                its own valid. A word-array model predicts read data,
//                latency and range errors (DMEM_RESPONDER_ERR_EN aware).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int WC [3] = '{0, 1, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        valid [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int tests = 0;
    int fails = 0;

    logic [31:0] mdl   [3][1024];
    bit          known [3][1024];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .dmem_valid_i(valid[0]), .dmem_ready_o(ready[0]),
        .dmem_addr_i(addr), .dmem_wdata_i(wdata), .dmem_we_i(we), .dmem_rdata_o(rdata[0])
`ifdef DMEM_RESPONDER_ERR_EN
        , .dmem_err_o(err[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .dmem_valid_i(valid[1]), .dmem_ready_o(ready[1]),
        .dmem_addr_i(addr), .dmem_wdata_i(wdata), .dmem_we_i(we), .dmem_rdata_o(rdata[1])
`ifdef DMEM_RESPONDER_ERR_EN
        , .dmem_err_o(err[1])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .dmem_valid_i(valid[2]), .dmem_ready_o(ready[2]),
        .dmem_addr_i(addr), .dmem_wdata_i(wdata), .dmem_we_i(we), .dmem_rdata_o(rdata[2])
`ifdef DMEM_RESPONDER_ERR_EN
        , .dmem_err_o(err[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request on instance d; checks latency, read data and error
    // against the model, then applies the write to the model.
    task automatic run_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] wen, input string tag, output logic [31:0] obs);
        int          idx;
        int          k;
        bit          got;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        obs_err;
        idx     = int'(a[11:2]);
        exp_err = ERR_EN && (a[31:12] != 20'h0);
        chk_rd  = exp_err || known[d][idx];
        exp_rd  = exp_err ? 32'h0 : mdl[d][idx];
        @(posedge clk); #1;
        addr = a; wdata = wd; we = wen; valid[d] = 1'b1;
        k = 0; got = 1'b0;
        while (!got && k < 32) begin
            @(negedge clk);
            if (ready[d] === 1'b1) got = 1'b1;
            else k++;
        end
        obs     = rdata[d];
        obs_err = err[d];
        chk({tag, "/latency"}, 32'(k), 32'(WC[d] + 1));
        if (chk_rd) chk({tag, "/rdata"}, obs, exp_rd);
`ifdef DMEM_RESPONDER_ERR_EN
        chk({tag, "/err"}, {31'h0, obs_err}, {31'h0, exp_err});
`endif
        @(posedge clk); #1;
        valid[d] = 1'b0;
        if (!exp_err) begin
            for (int i = 0; i < 4; i++)
                if (wen[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
            if (wen == 4'hF) known[d][idx] = 1'b1;
        end
    endtask

    logic [31:0] r;
    logic        rdy_s [6];
    logic [31:0] rd_s  [6];

    initial begin
        rst_n = 1'b0; addr = '0; wdata = '0; we = '0;
        for (int i = 0; i < 3; i++) valid[i] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state of all instances.
        for (int i = 0; i < 3; i++) begin
            chk("reset/ready", {31'h0, ready[i]}, 32'h0);
            chk("reset/rdata", rdata[i], 32'h0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-word write then read, one wait cycle.
        run_req(1, 32'h10, 32'hDEADBEEF, 4'hF, "w1_wr10", r);
        run_req(1, 32'h10, 32'h0, 4'h0, "w1_rd10", r);
        chk("w1_rd10/const", r, 32'hDEADBEEF);

        // Byte-lane write: returns the old word, only lane 2 changes.
        run_req(1, 32'h20, 32'h11223344, 4'hF, "lane_init", r);
        run_req(1, 32'h20, 32'h00AA0000, 4'b0100, "lane_wr", r);
        chk("lane_wr/const", r, 32'h11223344);
        run_req(1, 32'h22, 32'h0, 4'h0, "lane_rd", r);
        chk("lane_rd/const", r, 32'h11AA3344);

        // Abort with three wait cycles: valid dropped in cycle 2.
        run_req(2, 32'h30, 32'h5555AAAA, 4'hF, "abort_init", r);
        @(posedge clk); #1;
        addr = 32'h30; wdata = 32'hFFFFFFFF; we = 4'hF; valid[2] = 1'b1;
        @(negedge clk); chk("abort/c0_ready", {31'h0, ready[2]}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); chk("abort/c1_ready", {31'h0, ready[2]}, 32'h0);
        @(posedge clk); #1;
        valid[2] = 1'b0;
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("abort/c%0d_ready", c), {31'h0, ready[2]}, 32'h0);
        end
        run_req(2, 32'h30, 32'h0, 4'h0, "abort_rd", r);
        chk("abort_rd/const", r, 32'h5555AAAA);

        // Back-to-back reads with zero wait: ready in cycles 1 and 3 only.
        run_req(0, 32'h40, 32'hA0A0A0A0, 4'hF, "b2b_init40", r);
        run_req(0, 32'h44, 32'hB1B1B1B1, 4'hF, "b2b_init44", r);
        @(posedge clk); #1;
        addr = 32'h40; we = 4'h0; wdata = 32'h0; valid[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rdy_s[c] = ready[0];
            rd_s[c]  = rdata[0];
            @(posedge clk); #1;
            if (c == 1) addr = 32'h44;
            if (c == 3) valid[0] = 1'b0;
        end
        for (int c = 0; c < 6; c++)
            chk($sformatf("b2b/c%0d_ready", c), {31'h0, rdy_s[c]}, (c == 1 || c == 3) ? 32'h1 : 32'h0);
        chk("b2b/c1_rdata", rd_s[1], 32'hA0A0A0A0);
        chk("b2b/c3_rdata", rd_s[3], 32'hB1B1B1B1);

        // Reset while in WAIT: no write, outputs cleared, array kept.
        @(posedge clk); #1;
        addr = 32'h30; wdata = 32'h0; we = 4'hF; valid[2] = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rstwait/ready", {31'h0, ready[i]}, 32'h0);
            chk("rstwait/rdata", rdata[i], 32'h0);
        end
        valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstwait/rdata_after", rdata[2], 32'h0);
        run_req(2, 32'h30, 32'h0, 4'h0, "rstwait_rd", r);
        chk("rstwait_rd/const", r, 32'h5555AAAA);
        run_req(1, 32'h10, 32'h0, 4'h0, "rstwait_rd10", r);
        chk("rstwait_rd10/const", r, 32'hDEADBEEF);

        // Out-of-range address: error or wrap depending on the build.
        run_req(1, 32'h0, 32'hCAFEF00D, 4'hF, "range_init", r);
        run_req(1, 32'h00100000, 32'h12345678, 4'hF, "range_wr", r);
`ifdef DMEM_RESPONDER_ERR_EN
        chk("range_wr/const", r, 32'h0);
        run_req(1, 32'h0, 32'h0, 4'h0, "range_rd", r);
        chk("range_rd/const", r, 32'hCAFEF00D);
`else
        chk("range_wr/const", r, 32'hCAFEF00D);
        run_req(1, 32'h0, 32'h0, 4'h0, "range_rd", r);
        chk("range_rd/const", r, 32'h12345678);
`endif

        // Randomized traffic against the model on every instance.
        for (int d = 0; d < 3; d++) begin
            for (int j = 0; j < 8; j++)
                run_req(d, 32'(256 + 4 * j), $urandom, 4'hF, "rnd_init", r);
            for (int n = 0; n < 30; n++) begin
                logic [31:0] a;
                logic [19:0] up;
                up = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0;
                a  = {up, 10'(64 + $urandom_range(0, 7)), 2'($urandom)};
                run_req(d, a, $urandom, 4'($urandom), $sformatf("rnd_d%0d_%0d", d, n), r);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
